// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared defaults for the multi-port register file.
// Build option: REGFILE_BYPASS_EN enables same-cycle write-to-read bypass.
`default_nettype none

package regfile_mp_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  // Address width for n entries, never below 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_mp_scoreboard.sv
// regfile_scoreboard: busy bits with set-over-clear priority and per-port
// next-state busy lookup.
`default_nettype none

module regfile_scoreboard #(
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NREG-1:0]   busy_vec,
  output logic [NRD-1:0]    rd_busy_nxt
);

  logic [NREG-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy_vec;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && (int'(wr_addr[w*AW +: AW]) < NREG))
        busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
    end
    // The issuing instruction is the newer producer, so its set wins.
    if (iss_en && (int'(iss_addr) < NREG))
      busy_nxt[iss_addr] = 1'b1;
    if (ZERO_REG != 0)
      busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_vec <= '0;
    else     busy_vec <= busy_nxt;
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd_busy
    logic [AW-1:0] addr;
    assign addr = rd_addr[r*AW +: AW];
    assign rd_busy_nxt[r] = (int'(addr) < NREG) ? busy_nxt[addr] : 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// regfile_mp: NRD registered read ports, NWR prioritised write ports, busy scoreboard.
// Build option: REGFILE_BYPASS_EN (see regfile_mp_pkg) enables write-to-read bypass.
`default_nettype none

module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NREG     = NREG_DEF,
  parameter  int NRD      = 2,
  parameter  int NWR      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [NREG-1:0]     busy_vec
);

  logic [XLEN-1:0] regs [NREG];
  logic [NWR-1:0]  wr_ok;
  logic [NRD-1:0]  rd_busy_nxt;

  // A write is stored only when in range and not aimed at a hardwired zero.
  always_comb begin
    for (int w = 0; w < NWR; w++) begin
      wr_ok[w] = wr_en[w] && (int'(wr_addr[w*AW +: AW]) < NREG) &&
                 !((ZERO_REG != 0) && (wr_addr[w*AW +: AW] == '0));
    end
  end

  // Later iterations override earlier ones: the highest port wins a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_ok[w]) regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
      end
    end
  end

  regfile_scoreboard #(
    .NREG     (NREG),
    .NRD      (NRD),
    .NWR      (NWR),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .iss_en      (iss_en),
    .iss_addr    (iss_addr),
    .rd_addr     (rd_addr),
    .busy_vec    (busy_vec),
    .rd_busy_nxt (rd_busy_nxt)
  );

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] val;

    assign addr = rd_addr[r*AW +: AW];

    always_comb begin
      val = '0;
      if ((int'(addr) < NREG) && !((ZERO_REG != 0) && (addr == '0)))
        val = regs[addr];
      if (BYPASS_EN) begin
        for (int w = 0; w < NWR; w++) begin
          if (wr_ok[w] && (wr_addr[w*AW +: AW] == addr))
            val = wr_data[w*XLEN +: XLEN];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data[r*XLEN +: XLEN] <= '0;
        rd_busy[r]              <= 1'b0;
      end else if (rd_en[r]) begin
        rd_data[r*XLEN +: XLEN] <= val;
        rd_busy[r]              <= rd_busy_nxt[r];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed stimulus against a queue-based scoreboard.
`default_nettype none

module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 24;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int ZR   = 1;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [NREG-1:0]     busy_vec;

  regfile_mp #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG(ZR)
  ) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NRD*XLEN-1:0] data;
    logic [NRD-1:0]      busy;
    logic [NREG-1:0]     bv;
    string               tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: architectural registers, busy bits, and read-port outputs.
  logic [XLEN-1:0]     mreg [NREG];
  logic [NREG-1:0]     mbusy;
  logic [NRD*XLEN-1:0] mrd_data;
  logic [NRD-1:0]      mrd_busy;

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mreg[i] = '0;
    mbusy    = '0;
    mrd_data = '0;
    mrd_busy = '0;
  endtask

  task automatic model_step();
    logic [XLEN-1:0] nreg [NREG];
    logic [NREG-1:0] nb;
    if (rst) begin
      model_reset();
      return;
    end
    nreg = mreg;
    nb   = mbusy;
    for (int w = 0; w < NWR; w++) begin
      int a;
      a = int'(wr_addr[w*AW +: AW]);
      if (wr_en[w] && a < NREG) begin
        nb[a] = 1'b0;
        if (!(ZR != 0 && a == 0)) nreg[a] = wr_data[w*XLEN +: XLEN];
      end
    end
    if (iss_en && int'(iss_addr) < NREG) nb[int'(iss_addr)] = 1'b1;
    if (ZR != 0) nb[0] = 1'b0;
    for (int r = 0; r < NRD; r++) begin
      if (rd_en[r]) begin
        int a;
        logic [XLEN-1:0] d;
        logic b;
        a = int'(rd_addr[r*AW +: AW]);
        d = '0;
        b = 1'b0;
        if (a < NREG && !(ZR != 0 && a == 0)) begin
          d = mreg[a];
`ifdef REGFILE_BYPASS_EN
          for (int w = 0; w < NWR; w++)
            if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) d = wr_data[w*XLEN +: XLEN];
`endif
          b = nb[a];
        end
        mrd_data[r*XLEN +: XLEN] = d;
        mrd_busy[r] = b;
      end
    end
    mreg  = nreg;
    mbusy = nb;
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.data = mrd_data;
    e.busy = mrd_busy;
    e.bv   = mbusy;
    e.tag  = tag;
    q.push_back(e);
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic issue(input int a);
    iss_en = 1'b1;
    iss_addr = AW'(a);
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    push(tag);
    #1;
    idle();
  endtask

  // Monitor: the DUT presents a new state every cycle; compare it mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (rd_data !== e.data) begin
          errors++;
          $display("FAIL %s rd_data: got %h, expected %h", e.tag, rd_data, e.data);
        end
        checks++;
        if (rd_busy !== e.busy) begin
          errors++;
          $display("FAIL %s rd_busy: got %b, expected %b", e.tag, rd_busy, e.busy);
        end
        checks++;
        if (busy_vec !== e.bv) begin
          errors++;
          $display("FAIL %s busy_vec: got %h, expected %h", e.tag, busy_vec, e.bv);
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    push("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Populate register 5 and a read port, then assert reset mid-cycle.
    set_wr(0, 5, 32'hDEADBEEF); issue(6); step("wr5");
    set_rd(0, 5); set_rd(1, 6); step("rd5");
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    push("async_reset");
    set_wr(1, 5, 32'h55555555); issue(5);
    step("reset_hold");
    rst = 1'b0;
    set_rd(0, 5); set_rd(1, 5); step("rd5_after_reset");

    set_wr(0, 3, 32'h12345678); step("wr3");
    set_rd(0, 3); set_rd(1, 3); step("rd3");

    set_wr(0, 7, 32'h1111); set_wr(1, 7, 32'h2222); step("collide7");
    set_rd(1, 7); step("rd7");

    set_wr(0, 9, 32'hCAFE); set_rd(1, 9); step("bypass9");
    set_rd(0, 9); step("rd9");

    set_wr(1, 0, 32'hFFFF); issue(0); set_rd(0, 0); step("zero_wr");
    set_rd(0, 0); set_rd(1, 0); step("zero_rd");

    issue(4); set_rd(0, 4); step("iss4");
    issue(4); set_wr(0, 4, 32'h44); set_rd(1, 4); step("iss_wr4");
    set_wr(1, 4, 32'h45); step("wr4_hold");
    step("hold");
    set_rd(0, 4); step("rd4");

    set_wr(0, 30, 32'hBAD); issue(30); set_rd(0, 30); set_rd(1, 23); step("out_of_range");

    for (int n = 0; n < 400; n++) begin
      rd_en   = NRD'($urandom);
      wr_en   = NWR'($urandom);
      for (int p = 0; p < NRD; p++)
        rd_addr[p*AW +: AW] = AW'($urandom_range(0, 31));
      for (int p = 0; p < NWR; p++) begin
        wr_addr[p*AW +: AW] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7))
                                                          : AW'($urandom_range(0, 31));
        wr_data[p*XLEN +: XLEN] = $urandom;
      end
      iss_en   = 1'($urandom);
      iss_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7))
                                             : AW'($urandom_range(0, 31));
      step($sformatf("rand%0d", n));
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the pipelined core, the successor to the single-write, dual-read register file. It provides NRD registered read ports and NWR write ports, an optional hardwired-zero register, same-cycle write-to-read bypass, per-port read enables for stall hold, and a busy-bit scoreboard. Decode reads operands and issues destination reservations; writeback writes results and releases the reservations.

## Interface
- XLEN, 32: register width in bits.
- NREG, 32: number of registers; AW = $clog2(NREG).
- NRD, 2: number of read ports.
- NWR, 2: number of write ports; a higher port index has higher priority.
- ZERO_REG, 1: 1 = register 0 reads as 0 and ignores writes and issues.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_en  in  NRD  per-port read enable; 0 holds the port's outputs.
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  registered read data.
- rd_busy  out  NRD  registered busy bit of the read register.
- wr_en  in  NWR  write enables.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- iss_en  in  1  reserve a destination register (set its busy bit).
- iss_addr  in  AW  register to reserve.
- busy_vec  out  NREG  current scoreboard state.

## Operation
- Reset (async, rst=1):
  - every register = 0.
  - busy_vec = 0.
  - rd_data = 0.
  - rd_busy = 0.
- Write:
  - on clk, each port with wr_en=1 writes its register.
  - Two ports on the same address: the highest-indexed port's data is stored.
  - With ZERO_REG=1, writes to register 0 are dropped.
  - An address >= NREG is dropped.
- Scoreboard:
  - A write (any port) clears busy[wr_addr].
  - iss_en sets busy[iss_addr].
  - Set and clear on the same address in the same cycle: set wins, because the new producer owns the register.
  - With ZERO_REG=1, busy[0] is always 0.
- Read:
  - when rd_en[i]=1, rd_data[i] is loaded with the register value and rd_busy[i] with the next-state busy bit (after this cycle's clear/set).
  - When rd_en[i]=0, both outputs hold.
  - An address >= NREG returns 0 with busy 0.
  - With ZERO_REG=1, a read of register 0 returns 0 with busy 0.
- Bypass (see Configuration): the read address matches a write in the same cycle.
- Reset asserted mid-operation: state clears immediately, and pending writes and issues in that cycle are lost.

## Timing
- Read latency is 1 cycle: the address is sampled at edge N and the data is valid after edge N.
- Write latency is 1 cycle: data written at edge N is readable by an address presented for edge N+1 without bypass, and for edge N with bypass.
- busy_vec changes after the edge following iss_en or wr_en.
- There are no handshakes; every port accepts every cycle.
- No combinational path from any input to any output.

## Configuration
- REGFILE_BYPASS_EN defined:
  - a read whose address matches an enabled write in the same cycle returns that write's data.
  - If several ports match, the highest-indexed matching port's data is returned.
  - A write dropped under ZERO_REG is not bypassed.
- REGFILE_BYPASS_EN undefined:
  - reads return the pre-write array contents.
  - The caller provides forwarding.
- rd_busy is next-state in both builds.

## Structure
- The shared package/header holds:
  - the default XLEN and NREG constants.
  - the REGFILE_BYPASS_EN default setting.
  - an address-width helper (clog2) used by the core.
- One sub-module is natural: regfile_scoreboard, which owns the busy bits, the set/clear priority, and next-state busy lookup per read port.
- The data array, write arbitration, bypass mux and read registers stay in regfile_mp.

## Test plan
- Reset: rst=1 mid-run after register 5 has been written with 0xDEADBEEF. Required: rd_data=0 and busy_vec=0 immediately; a read of register 5 after reset returns 0x00000000.
- Write/read: write 0x12345678 to register 3, then read it on both ports the next cycle. Required: both rd_data=0x12345678 one cycle after the address.
- Write collision: port 0 writes 0x1111 and port 1 writes 0x2222 to register 7 in the same cycle. Required: a later read returns 0x2222.
- Bypass: write 0xCAFE to register 9 while reading register 9 in the same cycle. Required: 0xCAFE with REGFILE_BYPASS_EN defined; the old value 0 without it.
- Zero register (ZERO_REG=1): write 0xFFFF and issue on register 0. Required: a read returns 0 with rd_busy=0, and busy_vec[0]=0.
- Scoreboard:
  - iss_en on register 4 → busy_vec[4]=1, and a read shows rd_busy=1.
  - Next cycle, iss_en on 4 together with a write to 4 → busy stays 1.
  - Write to 4 alone → busy_vec[4]=0.
  - rd_en=0 holds the prior rd_data and rd_busy throughout.
